// File: rtl/cpu_mem_pkg.sv
// Purpose : shared types and default sizing for the core's data memory bank.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: mem_state_t (INIT sweep / IDLE service) and the core's default geometry.
package cpu_mem_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_DEPTH  = 16;
    localparam int CPU_ADDR_W = 4;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Purpose : DEPTH x WIDTH storage, one synchronous write port, one synchronous read port, no reset.
// Latency : read data registered, valid the cycle after i_rd_en; write lands at the same edge.
// Backpressure : none; both ports accept every cycle.
// Ports: i_clk; i_wr_en/i_wr_addr/i_wr_dat write port; i_rd_en/i_rd_addr read request; o_rd_dat read register.
module mem_array #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_dat,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    // Callers only present in-range addresses on either port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/data_mem_bank.sv
// Purpose : data memory for the core: valid/ready request port, zero-fill sweep, range/parity error.
// Latency : reads respond 1 cycle after accept; writes commit at the accept edge; errors flag 1 cycle later.
// Backpressure : req_ready low during the sweep and on a clear_in cycle; responses cannot be stalled.
// Ports: clka, restart_n (async, active low), clear_in, req_valid/req_ready/req_write/addr_in/wdata_in,
//        rsp_valid/data_out/err_out, busy_out.
// Build option PARITY_EN: adds an even-parity bit per word, parity error on read, and port par_inject_in.
module data_mem_bank
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int DEPTH  = CPU_DEPTH,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              clear_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
`ifdef PARITY_EN
    input  logic              par_inject_in,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              err_out,
    output logic              busy_out
);

`ifdef PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    logic              w_accept;
    logic              w_in_range;
    logic              w_sweep;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [MEM_W-1:0]  w_wr_dat;
    logic              w_rd_en;
    logic [MEM_W-1:0]  w_rd_dat;
    logic [DATA_W-1:0] w_rsp_dat;
    logic              w_par_err;

    logic              r_rsp_vld;
    logic              r_rng_err;
    logic [DATA_W-1:0] r_hold_dat;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // The sweep writes word[r_ptr] every INIT cycle, so DEPTH cycles clear the whole array.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        busy_out    = 1'b0;
        req_ready   = 1'b0;
        case (r_state)
            INIT: begin
                busy_out = 1'b1;
                if (clear_in) begin
                    w_ptr_nxt = '0;
                end else if (r_ptr == LAST_PTR) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                end
            end
            IDLE: begin
                req_ready = ~clear_in;
                if (clear_in) begin
                    w_state_nxt = INIT;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign w_accept   = req_valid & req_ready;
    assign w_in_range = ({1'b0, addr_in} < DEPTH_L);
    assign w_sweep    = (r_state == INIT);

    // Requests are never accepted during the sweep, so the write port has a single owner per cycle.
    assign w_wr_en   = w_sweep | (w_accept & req_write & w_in_range);
    assign w_wr_addr = w_sweep ? r_ptr : addr_in;
    assign w_rd_en   = w_accept & ~req_write & w_in_range;

`ifdef PARITY_EN
    // Stored bit makes the word even parity; the inject hook flips it to fake a corrupted cell.
    assign w_wr_dat  = w_sweep ? '0 : {(^wdata_in) ^ par_inject_in, wdata_in};
    assign w_par_err = r_rsp_vld & ~r_rng_err & (^w_rd_dat);
`else
    assign w_wr_dat  = w_sweep ? '0 : wdata_in;
    assign w_par_err = 1'b0;
`endif

    mem_array #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .i_clk     (clka),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_dat  (w_wr_dat),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (addr_in),
        .o_rd_dat  (w_rd_dat)
    );

    // r_rng_err covers both request kinds: with r_rsp_vld it is a read error, alone a dropped write.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_rsp_vld  <= 1'b0;
            r_rng_err  <= 1'b0;
            r_hold_dat <= '0;
        end else begin
            r_rsp_vld <= w_accept & ~req_write;
            r_rng_err <= w_accept & ~w_in_range;
            if (r_rsp_vld) begin
                r_hold_dat <= w_rsp_dat;
            end
        end
    end

    // Array read register is unreset and not loaded for out-of-range reads, hence the mask and hold copy.
    assign w_rsp_dat = r_rng_err ? '0 : w_rd_dat[DATA_W-1:0];
    assign rsp_valid = r_rsp_vld;
    assign data_out  = r_rsp_vld ? w_rsp_dat : r_hold_dat;
    assign err_out   = r_rng_err | w_par_err;

endmodule

// File: tb/tb_data_mem_bank.sv
// Bench for data_mem_bank: a DEPTH=16 and a DEPTH=12 instance share one stimulus stream.
// A behavioural model (array + sweep countdown) is compared against both instances every cycle,
// and directed literal expectations pin the main scenarios.
module tb_data_mem_bank;

    logic       clka = 1'b0;
    logic       restart_n;
    logic       clear_in;
    logic       req_valid;
    logic       req_write;
    logic [3:0] addr_in;
    logic [7:0] wdata_in;
    logic       par_inject_in;

    logic [1:0] rdy;
    logic [1:0] rsp;
    logic [1:0] err;
    logic [1:0] busy;
    logic [7:0] dat [2];

    int n_checks = 0;
    int n_errors = 0;
    bit done     = 1'b0;

    always #5 clka = ~clka;

    data_mem_bank #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) u_dut16 (
        .clka          (clka),
        .restart_n     (restart_n),
        .clear_in      (clear_in),
        .req_valid     (req_valid),
        .req_ready     (rdy[0]),
        .req_write     (req_write),
        .addr_in       (addr_in),
        .wdata_in      (wdata_in),
`ifdef PARITY_EN
        .par_inject_in (par_inject_in),
`endif
        .rsp_valid     (rsp[0]),
        .data_out      (dat[0]),
        .err_out       (err[0]),
        .busy_out      (busy[0])
    );

    data_mem_bank #(.DATA_W(8), .DEPTH(12), .ADDR_W(4)) u_dut12 (
        .clka          (clka),
        .restart_n     (restart_n),
        .clear_in      (clear_in),
        .req_valid     (req_valid),
        .req_ready     (rdy[1]),
        .req_write     (req_write),
        .addr_in       (addr_in),
        .wdata_in      (wdata_in),
`ifdef PARITY_EN
        .par_inject_in (par_inject_in),
`endif
        .rsp_valid     (rsp[1]),
        .data_out      (dat[1]),
        .err_out       (err[1]),
        .busy_out      (busy[1])
    );

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_busy [2];      // cycles of sweep still to run
    bit         m_rsp  [2];
    bit         m_err  [2];
    logic [7:0] m_last [2];      // value data_out presents
    logic [7:0] m_mem  [2][16];
    bit         m_pbad [2][16];  // word carries an injected parity fault

    function automatic int dep(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    task automatic model_clear(input int k);
        for (int a = 0; a < 16; a++) begin
            m_mem[k][a]  = 8'h00;
            m_pbad[k][a] = 1'b0;
        end
        m_busy[k] = dep(k);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_rsp[k]  = 1'b0;
            m_err[k]  = 1'b0;
            m_last[k] = 8'h00;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit ready;
            bit acc;
            bit inr;
            int a;
            a     = int'(addr_in);
            ready = (m_busy[k] == 0) && !clear_in;
            acc   = req_valid && ready;
            inr   = a < dep(k);
            m_rsp[k] = acc && !req_write;
            m_err[k] = acc && !inr;
            if (m_rsp[k]) begin
                if (inr) begin
                    m_last[k] = m_mem[k][a];
                    if (m_pbad[k][a]) m_err[k] = 1'b1;
                end else begin
                    m_last[k] = 8'h00;
                end
            end
            if (acc && req_write && inr) begin
                m_mem[k][a]  = wdata_in;
`ifdef PARITY_EN
                m_pbad[k][a] = par_inject_in;
`endif
            end
            if (clear_in) model_clear(k);
            else if (m_busy[k] > 0) m_busy[k]--;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clka or negedge restart_n);
            if (!restart_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clka);
            if (!done) begin
                for (int k = 0; k < 2; k++) begin
                    bit eb;
                    eb = m_busy[k] > 0;
                    chk("cmp_busy",  k, int'(busy[k]), int'(eb));
                    chk("cmp_ready", k, int'(rdy[k]),  int'(!eb && !clear_in));
                    chk("cmp_rsp",   k, int'(rsp[k]),  int'(m_rsp[k]));
                    chk("cmp_data",  k, int'(dat[k]),  int'(m_last[k]));
                    chk("cmp_err",   k, int'(err[k]),  int'(m_err[k]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clka);
        #2;
    endtask

    task automatic idle();
        req_valid     = 1'b0;
        req_write     = 1'b0;
        addr_in       = 4'h0;
        wdata_in      = 8'h00;
        par_inject_in = 1'b0;
        clear_in      = 1'b0;
    endtask

    task automatic drive(input bit wr, input int a, input int d, input bit inj);
        req_valid     = 1'b1;
        req_write     = wr;
        addr_in       = a[3:0];
        wdata_in      = d[7:0];
        par_inject_in = inj;
    endtask

    // Counts busy cycles of each instance until both are idle, bounded.
    task automatic count_busy(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clka);
            if (busy[0]) ca++;
            if (busy[1]) cb++;
            if (busy == 2'b00) break;
        end
        chk("sweep_timeout", 0, int'(busy), 0);
    endtask

    initial begin
        int ca;
        int cb;
        restart_n = 1'b1;
        idle();
        #1 restart_n = 1'b0;
        repeat (3) @(posedge clka);
        #3;
        chk("rst_busy",  0, int'(busy[0]), 1);
        chk("rst_ready", 0, int'(rdy[0]),  0);
        chk("rst_rsp",   0, int'(rsp[0]),  0);
        chk("rst_data",  0, int'(dat[0]),  0);
        chk("rst_err",   0, int'(err[0]),  0);
        restart_n = 1'b1;
        count_busy(ca, cb);
        chk("init_sweep_len", 0, ca, 16);
        chk("init_sweep_len", 1, cb, 12);
        tick();

        // every word reads back zero after the sweep
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, a, 0, 1'b0);
            tick();
            chk("zero_rd_rsp",  0, int'(rsp[0]), 1);
            chk("zero_rd_data", 0, int'(dat[0]), 0);
            chk("zero_rd_err",  0, int'(err[0]), 0);
        end
        idle();
        tick();

        // read-after-write on consecutive cycles
        drive(1'b1, 3, 'hA5, 1'b0);
        tick();
        chk("wr_no_rsp", 0, int'(rsp[0]), 0);
        drive(1'b0, 3, 0, 1'b0);
        tick();
        chk("raw_rsp",  0, int'(rsp[0]), 1);
        chk("raw_data", 0, int'(dat[0]), 'hA5);
        chk("raw_data", 1, int'(dat[1]), 'hA5);
        idle();
        tick();
        chk("hold_data", 0, int'(dat[0]), 'hA5);

        // streaming writes then reads, one per cycle
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, a, a ^ 'hFF, 1'b0);
            tick();
            if (a == 13) begin
                chk("oor_wr_err", 1, int'(err[1]), 1);
                chk("oor_wr_rsp", 1, int'(rsp[1]), 0);
            end
        end
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, a, 0, 1'b0);
            tick();
            chk("stream_rsp",  0, int'(rsp[0]), 1);
            chk("stream_data", 0, int'(dat[0]), a ^ 'hFF);
            if (a == 13) begin
                chk("oor_rd_rsp",  1, int'(rsp[1]), 1);
                chk("oor_rd_data", 1, int'(dat[1]), 0);
                chk("oor_rd_err",  1, int'(err[1]), 1);
            end
        end
        idle();
        tick();

        // clear sweep wipes stored data
        drive(1'b1, 7, 'h3C, 1'b0);
        tick();
        idle();
        clear_in = 1'b1;
        #1;
        chk("clr_ready_low", 0, int'(rdy[0]), 0);
        tick();
        clear_in = 1'b0;
        count_busy(ca, cb);
        chk("clr_sweep_len", 0, ca, 16);
        chk("clr_sweep_len", 1, cb, 12);
        tick();
        drive(1'b0, 7, 0, 1'b0);
        tick();
        chk("clr_rd_rsp",  0, int'(rsp[0]), 1);
        chk("clr_rd_data", 0, int'(dat[0]), 0);
        idle();
        tick();

`ifdef PARITY_EN
        drive(1'b1, 2, 'h01, 1'b1);
        tick();
        drive(1'b0, 2, 0, 1'b0);
        tick();
        chk("par_data", 0, int'(dat[0]), 'h01);
        chk("par_err",  0, int'(err[0]), 1);
        idle();
        tick();
`endif

        // reset during a pending request
        drive(1'b1, 1, 'h5A, 1'b0);
        tick();
        drive(1'b0, 1, 0, 1'b0);
        tick();
        chk("pre_rst_data", 0, int'(dat[0]), 'h5A);
        restart_n = 1'b0;
        #1;
        chk("midreq_rsp",   0, int'(rsp[0]),  0);
        chk("midreq_data",  0, int'(dat[0]),  0);
        chk("midreq_busy",  0, int'(busy[0]), 1);
        chk("midreq_ready", 0, int'(rdy[0]),  0);
        tick();
        idle();
        restart_n = 1'b1;

        // reset during the sweep restarts it from the first word
        repeat (5) tick();
        restart_n = 1'b0;
        #1;
        chk("midsweep_busy",  0, int'(busy[0]), 1);
        chk("midsweep_ready", 0, int'(rdy[0]),  0);
        tick();
        restart_n = 1'b1;
        count_busy(ca, cb);
        chk("rst_sweep_len", 0, ca, 16);
        chk("rst_sweep_len", 1, cb, 12);
        tick();
        drive(1'b0, 1, 0, 1'b0);
        tick();
        chk("post_rst_data", 0, int'(dat[0]), 0);
        chk("post_rst_rsp",  0, int'(rsp[0]), 1);
        idle();
        repeat (2) tick();

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
